adder_chunked_acc_amisha: RTL
=============================

// Module: adder_chunked_acc_amisha
// PURPOSE
//  Parametrised multi-cycle adder/subtractor/accumulator, successor to the fixed 4-bit carry adder.
//  Adds N-bit operands W bits per clock, LSB chunk first, with a ripple carry register between chunks.
//  Adds subtract, running-accumulate and clear modes, a signed-overflow flag and a start/done handshake.
//  Used wherever wide arithmetic must meet timing with a narrow carry chain.
// PARAMETERS
//  N  16  operand/result width in bits; must be a multiple of W
//  W  4   chunk width processed per cycle; CHUNKS = N/W (localparam)
// PORTS
//  clk_amisha    in   1  single clock; all state updates on rising edge
//  reset_amisha  in   1  synchronous, active-high reset
//  start_amisha  in   1  request; sampled only in IDLE
//  op_amisha     in   2  00 ADD, 01 SUB, 10 ACC, 11 CLR; latched with start
//  a_amisha      in   N  operand A (ADD/SUB), addend (ACC); latched with start
//  b_amisha      in   N  operand B (ADD/SUB); ignored in ACC/CLR
//  sum_amisha    out  N  registered result; held until the next done
//  cout_amisha   out  1  carry out of bit N-1; for SUB, 1 = no borrow
//  ovf_amisha    out  1  two's-complement signed overflow of the result
//  acc_amisha    out  N  accumulator register
//  busy_amisha   out  1  high in RUN and DONE
//  done_amisha   out  1  one-cycle pulse; result outputs valid from this cycle
// BEHAVIOUR
//  Reset (any state, incl. mid-RUN): state=IDLE; sum, cout, ovf, acc, busy, done all 0; operand regs and chunk index cleared.
//  FSM: IDLE -> RUN on start with op!=CLR; IDLE -> DONE on start with op=CLR; RUN -> DONE after CHUNKS cycles; DONE -> IDLE.
//  start outside IDLE ignored, no queueing; start held high re-triggers on each return to IDLE.
//  Operand mapping at latch: ADD X=a, Y=b, cin=0; SUB X=a, Y=~b, cin=1; ACC X=acc, Y=a, cin=0.
//  RUN cycle k (0..CHUNKS-1): {c, s[k*W+:W]} = X[k*W+:W] + Y[k*W+:W] + c; c starts at cin.
//  Latency: start at cycle t -> done high at t+CHUNKS+1 (CLR: t+1). One op per CHUNKS+2 cycles max.
//  In DONE: sum=s, cout=final c, ovf=(X[N-1]==Y[N-1]) && (s[N-1]!=X[N-1]), done=1.
//  ACC additionally writes acc=s in DONE; ADD/SUB never change acc.
//  CLR: in DONE sum=0, cout=0, ovf=0, acc=0.
//  Wrap-around: results are modulo 2^N; carry/overflow reported only via cout/ovf.
//  Between done pulses, sum/cout/ovf/acc hold their last value; partial sums never visible.
//  Elaboration fails if N%W!=0 or W<1.
// STRUCTURE
//  Shared package adder_pkg_amisha: op encodings (OP_ADD/SUB/ACC/CLR), FSM state encodings.
//  Sub-module adder_slice_amisha: combinational W-bit slice, (x, y, cin) -> (s, cout); one instance, reused per cycle.
//  Top: FSM, chunk counter (clog2(CHUNKS) bits), operand/result shift-or-index registers, carry flop, acc.
// TESTING (N=16, W=4)
//  ADD 16'hFFFF + 16'h0001 -> done at t+5; sum=16'h0000, cout=1, ovf=0; acc unchanged.
//  SUB 16'h8000 - 16'h0001 -> sum=16'h7FFF, cout=1, ovf=1; SUB 16'h0001 - 16'h0002 -> sum=16'hFFFF, cout=0, ovf=0.
//  CLR, then ACC 16'h7FFF twice -> acc=16'h7FFF (ovf=0), then acc=16'hFFFE (ovf=1, cout=0).
//  Pulse start in RUN with different operands -> ignored; result equals the first op; busy stays high.
//  Reset asserted on RUN chunk 2 -> next cycle all outputs 0, state IDLE; next start completes normally.
//  start held high, ADD 16'h1234 + 16'h4321 -> repeated done pulses 6 cycles apart, each sum=16'h5555.

Source files
------------

// File: rtl/adder_pkg_amisha.sv
// Shared encodings for the chunked adder/accumulator.
// Operation codes and FSM states.
package adder_pkg_amisha;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/adder_slice_amisha.sv
// One W-bit ripple slice of the chunked adder.
// Reused every RUN cycle on a different chunk.
module adder_slice_amisha #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] total;

  // Full W-bit add with carry in; carry out is the extra MSB
  always_comb begin
    total = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    s     = total[W-1:0];
    cout  = total[W];
  end

endmodule

// File: rtl/adder_chunked_acc_amisha.sv
// Multi-cycle N-bit add/sub/accumulate, W bits per clock.
// LSB chunk first, carry held in a flop between chunks.
module adder_chunked_acc_amisha
  import adder_pkg_amisha::*;
#(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk_amisha,
  input  logic         reset_amisha,
  input  logic         start_amisha,
  input  logic [1:0]   op_amisha,
  input  logic [N-1:0] a_amisha,
  input  logic [N-1:0] b_amisha,
  output logic [N-1:0] sum_amisha,
  output logic         cout_amisha,
  output logic         ovf_amisha,
  output logic [N-1:0] acc_amisha,
  output logic         busy_amisha,
  output logic         done_amisha
);

  localparam int WS     = (W < 1) ? 1 : W;
  localparam int CHUNKS = N / WS;
  localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  if ((W < 1) || ((N % WS) != 0)) begin : g_bad_params
    $error("N must be a positive multiple of W");
  end

  state_t          state;
  state_t          state_next;
  op_t             op_r;
  logic [N-1:0]    x_r;
  logic [N-1:0]    y_r;
  logic [N-1:0]    s_r;
  logic [N-1:0]    s_full;
  logic            c_r;
  logic [IW-1:0]   idx;
  logic [WS-1:0]   xs;
  logic [WS-1:0]   ys;
  logic [WS-1:0]   ss;
  logic            sc;
  logic            last;

  // Select the current chunk and merge its result into the partial sum
  always_comb begin
    xs     = x_r[idx*WS +: WS];
    ys     = y_r[idx*WS +: WS];
    last   = (idx == IW'(CHUNKS - 1));
    s_full = s_r;
    s_full[idx*WS +: WS] = ss;
  end

  adder_slice_amisha #(
    .W (WS)
  ) u_slice (
    .x    (xs),
    .y    (ys),
    .cin  (c_r),
    .s    (ss),
    .cout (sc)
  );

  // State register
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) state <= ST_IDLE;
    else              state <= state_next;
  end

  // Next-state logic; CLR needs no chunk pass
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (start_amisha) begin
          if (op_t'(op_amisha) == OP_CLR) state_next = ST_DONE;
          else                            state_next = ST_RUN;
        end
      end
      ST_RUN:  if (last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand latch, chunk walk and result commit on the last chunk
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      op_r        <= OP_ADD;
      x_r         <= '0;
      y_r         <= '0;
      s_r         <= '0;
      c_r         <= 1'b0;
      idx         <= '0;
      sum_amisha  <= '0;
      cout_amisha <= 1'b0;
      ovf_amisha  <= 1'b0;
      acc_amisha  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          idx <= '0;
          if (start_amisha) begin
            op_r <= op_t'(op_amisha);
            unique case (op_t'(op_amisha))
              OP_ADD: begin
                x_r <= a_amisha;
                y_r <= b_amisha;
                c_r <= 1'b0;
              end
              OP_SUB: begin
                x_r <= a_amisha;
                y_r <= ~b_amisha;
                c_r <= 1'b1;
              end
              OP_ACC: begin
                x_r <= acc_amisha;
                y_r <= a_amisha;
                c_r <= 1'b0;
              end
              OP_CLR: begin
                sum_amisha  <= '0;
                cout_amisha <= 1'b0;
                ovf_amisha  <= 1'b0;
                acc_amisha  <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          s_r <= s_full;
          c_r <= sc;
          idx <= idx + IW'(1);
          if (last) begin
            sum_amisha  <= s_full;
            cout_amisha <= sc;
            ovf_amisha  <= (x_r[N-1] == y_r[N-1]) &&
                           (s_full[N-1] != x_r[N-1]);
            if (op_r == OP_ACC) acc_amisha <= s_full;
          end
        end
        ST_DONE: idx <= '0;
        default: idx <= '0;
      endcase
    end
  end

  assign busy_amisha = (state != ST_IDLE);
  assign done_amisha = (state == ST_DONE);

endmodule
